// File: rtl/divsqrt_result_queue_pkg.sv
// Shared configuration and result-entry payload for the div/rem/sqrt result path.
// Consumed by the result queue, the integer normalizer and the FP rounding stage.
package divsqrt_result_queue_pkg;

  // Core configuration (RV64 with double-precision divider)
  localparam int unsigned XLEN    = 64;  // integer register width
  localparam int unsigned NE      = 11;  // FP exponent width
  localparam int unsigned DIVb    = 59;  // divider mantissa bits (mantissa is DIVb+1 wide)
  localparam int unsigned INTDIVb = 64;  // integer divider datapath bits
  localparam int unsigned DIVBLEN = 7;   // width of normalization shift amount

  localparam int unsigned UM_W  = DIVb + 1;
  localparam int unsigned UE_W  = NE + 2;
  localparam int unsigned PRE_W = INTDIVb + 4;

  // One completed divider operation as seen by the rounding / writeback stage
  typedef struct packed {
    logic              IntDiv;
    logic              Sqrt;
    logic              Special;
    logic              Sticky;
    logic [UM_W-1:0]   Um;
    logic [UE_W-1:0]   Ue;
    logic [XLEN-1:0]   IntResult;
  } divres_entry_t;

endpackage

// File: rtl/divsqrt_intnorm.sv
// Integer result normalization: arithmetic right shift of the pre-normalized
// divider result, then optional 32-bit sign extension for W-type ops on RV64.
//  PreResult   in  PRE_W    pre-normalized integer result (signed)
//  NormShift   in  DIVBLEN  right-shift amount
//  W64         in  1        sign-extend from bit 31
//  IntResult_c out XLEN     normalized integer result (combinational)
module divsqrt_intnorm
  import divsqrt_result_queue_pkg::*;
(
  input  logic [PRE_W-1:0]   PreResult,
  input  logic [DIVBLEN-1:0] NormShift,
  input  logic               W64,
  output logic [XLEN-1:0]    IntResult_c
);

  logic [XLEN-1:0] shifted;

  // Truncating cast keeps the low XLEN bits of the signed shift
  always_comb begin
    shifted = XLEN'($signed(PreResult) >>> NormShift);
    if (W64) IntResult_c = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
    else     IntResult_c = shifted;
  end

endmodule

// File: rtl/divsqrt_result_queue.sv
// In-order result buffer between the div/rem/sqrt unit and the rounding /
// integer writeback stage. Integer results are normalized on enqueue so the
// output path is a plain read of the head entry.
//  clk, reset (async active-low), FlushM (sync discard)
//  InValid/InReady + In* fields : producer side (divider)
//  OutValid/OutReady + Out* fields : consumer side (head entry, combinational read)
//  Count : occupancy
module divsqrt_result_queue
  import divsqrt_result_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushM,
  input  logic               InValid,
  output logic               InReady,
  input  logic               InIntDiv,
  input  logic               InW64,
  input  logic               InSqrt,
  input  logic               InSpecial,
  input  logic [UM_W-1:0]    InUm,
  input  logic [UE_W-1:0]    InUe,
  input  logic               InSticky,
  input  logic [PRE_W-1:0]   InPreResult,
  input  logic [DIVBLEN-1:0] InNormShift,
  output logic               OutValid,
  input  logic               OutReady,
  output logic               OutIntDiv,
  output logic               OutSqrt,
  output logic               OutSpecial,
  output logic               OutSticky,
  output logic [UM_W-1:0]    OutUm,
  output logic [UE_W-1:0]    OutUe,
  output logic [XLEN-1:0]    OutIntResult,
  output logic [CW-1:0]      Count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  divres_entry_t   mem [DEPTH];
  divres_entry_t   inEntry;
  divres_entry_t   head;
  logic [PW-1:0]   rdPtr, wrPtr;
  logic [XLEN-1:0] normResult;
  logic            full, enq, deq;

  divsqrt_intnorm u_intnorm (
    .PreResult   (InPreResult),
    .NormShift   (InNormShift),
    .W64         (InW64),
    .IntResult_c (normResult)
  );

  // Handshake: a full queue still accepts when its head leaves this cycle
  always_comb begin
    full     = (Count == CW'(DEPTH));
    OutValid = (Count != '0);
    deq      = OutValid && OutReady;
    InReady  = !full || deq;
    enq      = InValid && InReady;
  end

  // Entry build: FP and integer fields are mutually zeroed
  always_comb begin
    inEntry         = '0;
    inEntry.IntDiv  = InIntDiv;
    inEntry.Sqrt    = InSqrt;
    inEntry.Special = InSpecial;
    if (InIntDiv) begin
      inEntry.IntResult = normResult;
    end else begin
      inEntry.Um     = InUm;
      inEntry.Ue     = InUe;
      inEntry.Sticky = InSticky;
    end
  end

  // Storage, pointers and occupancy; flush overrides same-cycle enq/deq
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      Count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (FlushM) begin
      rdPtr <= '0;
      wrPtr <= '0;
      Count <= '0;
    end else begin
      if (enq) begin
        mem[wrPtr] <= inEntry;
        wrPtr      <= wrPtr + PW'(1);
      end
      if (deq) rdPtr <= rdPtr + PW'(1);
      if (enq && !deq)      Count <= Count + CW'(1);
      else if (!enq && deq) Count <= Count - CW'(1);
    end
  end

  // Head entry read
  always_comb begin
    head         = mem[rdPtr];
    OutIntDiv    = head.IntDiv;
    OutSqrt      = head.Sqrt;
    OutSpecial   = head.Special;
    OutSticky    = head.Sticky;
    OutUm        = head.Um;
    OutUe        = head.Ue;
    OutIntResult = head.IntResult;
  end

  // Occupancy must never pass DEPTH
  a_noOverflow: assert property (@(posedge clk) disable iff (!reset)
    !(enq && full && !deq) && (Count <= CW'(DEPTH)))
    else $error("result queue overflow");

endmodule
